// File: rtl/keypad_encoder_pkg.sv
// Shared types and key-map helpers for the keypad scanner and debouncer.
package keypad_encoder_pkg;

    localparam int unsigned NUM_COLS = 6;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned OP_COL   = 4;
    localparam int unsigned EQ_COL   = 5;
    localparam int unsigned KEY_W    = 5;  // key index = col*NUM_ROWS + row

    typedef enum logic [1:0] {
        KEY_NONE,
        KEY_HEX,
        KEY_OP,
        KEY_EQ
    } key_class_e;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_KEY,
        SCAN_MULTI
    } scan_kind_e;

    typedef struct packed {
        scan_kind_e       kind;
        logic [KEY_W-1:0] key;
    } scan_result_t;

    function automatic key_class_e key_class(input logic [KEY_W-1:0] key);
        logic [2:0] c;
        logic [1:0] r;
        c = key[4:2];
        r = key[1:0];
        if (c < 3'(OP_COL))                      return KEY_HEX;
        else if (c == 3'(OP_COL))                return KEY_OP;
        else if (c == 3'(EQ_COL) && r == 2'd0)   return KEY_EQ;
        else                                     return KEY_NONE;
    endfunction

    // Hex digit is 4*row + col for the four hex columns.
    function automatic logic [3:0] hex_digit(input logic [KEY_W-1:0] key);
        return {key[1:0], key[3:2]};
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Scan-rate debouncer: turns per-scan results into single-cycle key events.
module keypad_debounce
    import keypad_encoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         scan_done,
    input  scan_result_t scan_res,
    output logic         newhex,
    output logic [3:0]   hexcode,
    output logic         newop,
    output logic [1:0]   opcode,
    output logic         eq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAND,
        ST_HELD,
        ST_REL
    } state_e;

    state_e           state_q, state_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             newhex_q, newhex_d;
    logic [3:0]       hexcode_q, hexcode_d;
    logic             newop_q, newop_d;
    logic [1:0]       opcode_q, opcode_d;
    logic             eq_q, eq_d;
    logic             accept;

    // State, counter and event registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            newhex_q  <= 1'b0;
            hexcode_q <= '0;
            newop_q   <= 1'b0;
            opcode_q  <= '0;
            eq_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            newhex_q  <= newhex_d;
            hexcode_q <= hexcode_d;
            newop_q   <= newop_d;
            opcode_q  <= opcode_d;
            eq_q      <= eq_d;
        end
    end

    // Next-state evaluation once per scan end, plus event encoding on accept.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        newhex_d  = 1'b0;
        hexcode_d = hexcode_q;
        newop_d   = 1'b0;
        opcode_d  = opcode_q;
        eq_d      = 1'b0;
        accept    = 1'b0;

        if (scan_done) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (scan_res.kind == SCAN_KEY) begin
                        if (CNT_DONE == CNT_W'(1)) begin
                            accept = 1'b1;
                        end else begin
                            state_d = ST_CAND;
                            cand_d  = scan_res.key;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_CAND: begin
                    if (scan_res.kind == SCAN_KEY && scan_res.key == cand_q) begin
                        if (cnt_q + CNT_W'(1) == CNT_DONE) accept = 1'b1;
                        else                                cnt_d  = cnt_q + CNT_W'(1);
                    end else if (scan_res.kind == SCAN_KEY) begin
                        cand_d = scan_res.key;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_HELD: begin
                    if (scan_res.kind == SCAN_NONE) begin
                        if (CNT_DONE == CNT_W'(1)) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_REL;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_REL: begin
                    if (scan_res.kind == SCAN_NONE) begin
                        if (cnt_q + CNT_W'(1) == CNT_DONE) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (accept) begin
            state_d = ST_HELD;
            cnt_d   = '0;
            unique case (key_class(scan_res.key))
                KEY_HEX: begin
                    newhex_d  = 1'b1;
                    hexcode_d = hex_digit(scan_res.key);
                end
                KEY_OP: begin
                    newop_d  = 1'b1;
                    opcode_d = scan_res.key[1:0];
                end
                KEY_EQ:  eq_d = 1'b1;
                default: ;
            endcase
        end
    end

    assign newhex  = newhex_q;
    assign hexcode = hexcode_q;
    assign newop   = newop_q;
    assign opcode  = opcode_q;
    assign eq      = eq_q;

endmodule

// File: rtl/keypad_encoder.sv
// Key matrix scanner: row synchronizer, column rotator and per-scan result encoder.
module keypad_encoder
    import keypad_encoder_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic                newhex,
    output logic [3:0]          hexcode,
    output logic                newop,
    output logic [1:0]          opcode,
    output logic                eq
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [NUM_ROWS-1:0] row_meta_q, row_meta_d;
    logic [NUM_ROWS-1:0] row_sync_q, row_sync_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [NUM_COLS-1:0] col_q, col_d;
    logic                acc_any_q, acc_any_d;
    logic                acc_multi_q, acc_multi_d;
    logic [KEY_W-1:0]    acc_key_q, acc_key_d;

    logic                dwell_end;
    logic                scan_done;
    logic [2:0]          col_idx;
    logic [1:0]          row_idx;
    logic [NUM_ROWS-1:0] live_rows;
    logic [2:0]          nbits;
    logic                any_now, multi_now;
    logic [KEY_W-1:0]    key_now;
    scan_result_t        scan_res;

    // Synchronizer, dwell counter, column drive and scan accumulator registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_meta_q  <= '0;
            row_sync_q  <= '0;
            div_q       <= '0;
            col_q       <= NUM_COLS'(1);
            acc_any_q   <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_key_q   <= '0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            div_q       <= div_d;
            col_q       <= col_d;
            acc_any_q   <= acc_any_d;
            acc_multi_q <= acc_multi_d;
            acc_key_q   <= acc_key_d;
        end
    end

    // Column rotation and folding each column's sample into the running scan result.
    always_comb begin
        row_meta_d = row;
        row_sync_d = row_meta_q;

        dwell_end = (div_q == DIV_LAST);
        div_d     = dwell_end ? '0 : div_q + DIV_W'(1);
        col_d     = dwell_end ? {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]} : col_q;

        col_idx = '0;
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            if (col_q[c]) col_idx = 3'(c);
        end

        // Only row 0 of the equals column is a real key.
        live_rows = row_sync_q;
        if (col_idx == 3'(EQ_COL)) live_rows[NUM_ROWS-1:1] = '0;

        nbits   = '0;
        row_idx = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            nbits = nbits + 3'(live_rows[r]);
            if (live_rows[r]) row_idx = 2'(r);
        end

        any_now   = acc_any_q | (nbits != 3'd0);
        multi_now = acc_multi_q | (nbits > 3'd1) | (acc_any_q & (nbits != 3'd0));
        key_now   = (nbits != 3'd0 && !acc_any_q) ? {col_idx, row_idx} : acc_key_q;

        scan_done = dwell_end && (col_idx == 3'(NUM_COLS - 1));

        if (multi_now)    scan_res.kind = SCAN_MULTI;
        else if (any_now) scan_res.kind = SCAN_KEY;
        else              scan_res.kind = SCAN_NONE;
        scan_res.key = key_now;

        acc_any_d   = acc_any_q;
        acc_multi_d = acc_multi_q;
        acc_key_d   = acc_key_q;
        if (scan_done) begin
            acc_any_d   = 1'b0;
            acc_multi_d = 1'b0;
            acc_key_d   = '0;
        end else if (dwell_end) begin
            acc_any_d   = any_now;
            acc_multi_d = multi_now;
            acc_key_d   = key_now;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clock    (clock),
        .reset    (reset),
        .scan_done(scan_done),
        .scan_res (scan_res),
        .newhex   (newhex),
        .hexcode  (hexcode),
        .newop    (newop),
        .opcode   (opcode),
        .eq       (eq)
    );

    assign col = col_q;

endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Scans the calculator's 4-row × 6-column key matrix, debounces it and encodes one accepted key press into the single-cycle event pulses (newhex/hexcode, newop/opcode, eq) consumed by the operand register block. It is the producer end of that keypad event interface and sits between the board key matrix pins and the register/arithmetic datapath.

## Interface
- SCAN_DIV, 1000: clock cycles each column is driven (dwell); ≥ 4
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results required to accept a press or a release; ≥ 1
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- row  in  4  matrix row sense, active-high (external pull-downs), asynchronous to clock
- col  out  6  column drive, one-hot active-high
- newhex  out  1  one-cycle pulse: hex key accepted
- hexcode  out  4  value of last accepted hex key, held
- newop  out  1  one-cycle pulse: operator key accepted
- opcode  out  2  last accepted operator, held
- eq  out  1  one-cycle pulse: equals key accepted

## Operation
- Key map: cols 0–3, row r, col c → hex digit 4·r + c; col 4, row r → operator, opcode = r; col 5 row 0 → equals; col 5 rows 1–3 unused, read as "no key".
- row passes through a 2-flop synchronizer before use.
- Scanner: col starts at 6'b000001, rotates left every SCAN_DIV cycles, wraps col 5 → col 0. Synchronized row sampled on the last dwell cycle of each column.
- Per full scan (cols 0..5) a scan result is formed: NONE (no bit set), KEY(code) (exactly one bit set in the whole scan), or MULTI (two or more). MULTI is treated as NONE for press purposes and as "not released" for release purposes.
- Debounce FSM, evaluated once per scan end:
  - IDLE: KEY(k) → CAND, cand=k, cnt=1 (if DEBOUNCE_SCANS=1, go directly to the accept action).
  - CAND: same KEY(k) → cnt+1; at cnt = DEBOUNCE_SCANS emit event for k, go HELD. Different key → restart CAND with new key, cnt=1. NONE/MULTI → IDLE.
  - HELD: NONE → REL, cnt=1 (accepted at DEBOUNCE_SCANS as for CAND). KEY/MULTI → stay HELD. No auto-repeat.
  - REL: NONE → cnt+1; at cnt = DEBOUNCE_SCANS → IDLE. Any KEY/MULTI → HELD.
- Event action: hex → newhex=1, hexcode←digit; operator → newop=1, opcode←r; equals → eq=1. At most one of newhex/newop/eq high in any cycle; codes updated in the same cycle as the pulse and held thereafter.

## Timing
- Reset values: col=6'b000001, newhex=newop=eq=0, hexcode=4'h0, opcode=2'b00, FSM IDLE, counters 0.
- Full scan = 6·SCAN_DIV cycles. Synchronizer adds 2 cycles; dwell ≥ 4 guarantees sampled value reflects the current column.
- A key stable from before scan N start produces its pulse in the cycle following the end of scan N+DEBOUNCE_SCANS−1 (the scan-end evaluation is registered; pulse width exactly 1 cycle).
- Next press accepted only after DEBOUNCE_SCANS clean NONE scans.
- Reset asserted mid-scan or mid-debounce: immediate return to reset values; pulses drop asynchronously; no event emitted on reset release.

## Structure
- Shared package: key-class enum (NONE, HEX, OP, EQ), NUM_COLS=6, NUM_ROWS=4, EQ_COL=5, OP_COL=4, scan-result type.
- Natural sub-module: keypad_debounce (scan-result in, event/code out, the IDLE/CAND/HELD/REL FSM); top keeps synchronizer, column rotator and scan-result encoder.

## Test plan
(SCAN_DIV=4, DEBOUNCE_SCANS=2, scan = 24 cycles)
- Reset release, no keys → col rotates 000001→000010 every 4 cycles, wraps after 24; no pulses.
- Press col2,row1 held 4 scans → single newhex pulse, hexcode=4'h6, one cycle after second scan end; nothing more until release.
- Press col4,row3, release, press col5,row0 → newop with opcode=2'b11, then eq pulse; hexcode unchanged.
- Key bouncing (present in alternate scans) → no pulse; then stable 2 scans → exactly one pulse.
- Two keys (hex 1 and hex 5) held together → no event; release one → event for the remaining key.
- Assert reset during CAND after one scan of hex A → outputs to reset values; after release, key still held → pulse after 2 fresh scans.
